seq_calculator: RTL and testbench



---
 rtl/seq_calculator.sv | 125 ++++++++++++
 tb/tb_seq_calculator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_calculator.sv
// seq_calculator: handshaked four-function calculator (responder side).
// SUM/SUB finish in one cycle; MUL is iterative shift-add and DIV is restoring
// division, each taking WIDTH cycles, so no wide single-cycle multiplier or divider.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   request present
//   in_ready   block can accept a request (high only when idle)
//   operation  0=SUM, 1=SUB, 2=MUL, 3=DIV
//   val1       augend / minuend / multiplicand / dividend
//   val2       addend / subtrahend / multiplier / divisor
//   out_valid  result present
//   out_ready  consumer takes result
//   out        registered result
module seq_calculator #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       operation,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);
  localparam logic [1:0] OpMul = 2'd2;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;    // multiplicand (shifts left) / dividend-then-quotient
  logic [WIDTH-1:0] b_q;    // multiplier (shifts right) / divisor
  logic [WIDTH-1:0] acc_q;  // product accumulator / partial remainder
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_q;

  // One iteration of each algorithm, computed from the current state.
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             div_bit;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;

  always_comb begin
    mul_acc  = b_q[0] ? acc_q + a_q : acc_q;
    // Bring the next dividend bit into the remainder; a_q doubles as the
    // quotient register as dividend bits shift out the top.
    rem_sh   = {acc_q, a_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    div_bit  = ~rem_diff[WIDTH];  // no borrow -> divisor fits -> quotient bit 1
    div_rem  = div_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    div_quo  = {a_q[WIDTH-2:0], div_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q       <= operation;
            a_q        <= val1;
            b_q        <= val2;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            if (!operation[1]) begin
              out_q       <= operation[0] ? val1 - val2 : val1 + val2;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          cnt_q <= cnt_q + 1'b1;
          if (op_q == OpMul) begin
            acc_q <= mul_acc;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
          end else begin
            acc_q <= div_rem;
            a_q   <= div_quo;
          end
          if (cnt_q == LastCnt) begin
            cnt_q       <= '0;
            out_q       <= (op_q == OpMul) ? mul_acc : div_quo;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

// File: tb/tb_seq_calculator.sv
module tb_seq_calculator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  operation = 2'd0;
  logic [31:0] val1 = '0;
  logic [31:0] val2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out;

  int n_total = 0;
  int n_pass  = 0;

  seq_calculator #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .operation(operation),
    .val1     (val1),
    .val2     (val2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until the accepting edge; leaves us in cycle 1.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    operation = o; val1 = a; val2 = b; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin tick(); n++; end
    n_total++;
    if (n >= 100) $display("FAIL issue_timeout: in_ready=%b required 1", in_ready);
    else n_pass++;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_total++;
    if (out_valid !== 1'b0 || out !== 32'h0 || in_ready !== 1'b1)
      $display("FAIL reset: out_valid=%b out=%h in_ready=%b required 0/00000000/1",
               out_valid, out, in_ready);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_sum_sub();
    logic [1:0]  ops[2]  = '{2'd0, 2'd1};
    logic [31:0] as[2]   = '{32'd5, 32'd3};
    logic [31:0] bs[2]   = '{32'd7, 32'd5};
    logic [31:0] exps[2] = '{32'd12, 32'hFFFF_FFFE};
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], as[i], bs[i]);
      n_total++;
      if (out_valid !== 1'b1 || out !== exps[i] || in_ready !== 1'b0)
        $display("FAIL sumsub_%0d: out_valid=%b out=%h in_ready=%b required 1/%h/0",
                 i, out_valid, out, in_ready, exps[i]);
      else n_pass++;
      drain();
      n_total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL sumsub_drain_%0d: out_valid=%b in_ready=%b required 0/1",
                 i, out_valid, in_ready);
      else n_pass++;
    end
  endtask

  task automatic test_mul_div();
    logic [1:0]  ops[5]  = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [31:0] as[5]   = '{32'h0000_FFFF, 32'h8000_0000, 32'd100, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] bs[5]   = '{32'h0001_0001, 32'd2, 32'd7, 32'd1, 32'd0};
    logic [31:0] exps[5] = '{32'hFFFF_FFFF, 32'h0, 32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      int cyc;
      issue(ops[i], as[i], bs[i]);
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL muldiv_busy_%0d: in_ready=%b required 0", i, in_ready);
      else n_pass++;
      cyc = 1;
      while (out_valid !== 1'b1 && cyc < 100) begin tick(); cyc++; end
      n_total++;
      if (cyc != 33) $display("FAIL muldiv_latency_%0d: cycle=%0d required 33", i, cyc);
      else n_pass++;
      n_total++;
      if (out !== exps[i]) $display("FAIL muldiv_value_%0d: out=%h required %h", i, out, exps[i]);
      else n_pass++;
      drain();
    end
  endtask

  task automatic test_backpressure();
    issue(2'd0, 32'd10, 32'd20);
    // New request held throughout the stall; must not be taken early.
    operation = 2'd0; val1 = 32'd1; val2 = 32'd2; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_total++;
      if (out_valid !== 1'b1 || out !== 32'd30 || in_ready !== 1'b0)
        $display("FAIL stall_%0d: out_valid=%b out=%0d in_ready=%b required 1/30/0",
                 i, out_valid, out, in_ready);
      else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b1 || out !== 32'd3)
      $display("FAIL bp_next: out_valid=%b out=%0d required 1/3", out_valid, out);
    else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    issue(2'd3, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || out !== 32'h0 || in_ready !== 1'b1)
      $display("FAIL mid_reset: out_valid=%b out=%h in_ready=%b required 0/00000000/1",
               out_valid, out, in_ready);
    else n_pass++;
    issue(2'd0, 32'd1, 32'd1);
    n_total++;
    if (out_valid !== 1'b1 || out !== 32'd2)
      $display("FAIL after_reset: out_valid=%b out=%0d required 1/2", out_valid, out);
    else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] expq[$];
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    int errs = 0;
    while (got < 1000 && cyc < 60000) begin
      logic [31:0] a, b, e;
      // Choose this cycle's inputs, then resolve both handshakes for the next edge.
      out_ready = ($urandom_range(0, 9) < 6);
      if (sent < 1000 && $urandom_range(0, 9) < 7) begin
        in_valid  = 1'b1;
        operation = 2'($urandom_range(0, 3));
        val1      = $urandom();
        case ($urandom_range(0, 3))
          0:       val2 = 32'd0;
          1:       val2 = 32'($urandom_range(1, 255));
          default: val2 = $urandom();
        endcase
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready === 1'b1) begin
        a = val1; b = val2;
        case (operation)
          2'd0:    e = a + b;
          2'd1:    e = a - b;
          2'd2:    e = a * b;
          default: e = (b == 0) ? 32'hFFFF_FFFF : a / b;
        endcase
        expq.push_back(e);
        sent++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_total++;
        if (expq.size() == 0) begin
          $display("FAIL b2b_spurious: response %h with nothing outstanding", out);
          errs++;
        end else begin
          e = expq.pop_front();
          if (out !== e) begin
            if (errs < 10) $display("FAIL b2b_%0d: out=%h required %h", got, out, e);
            errs++;
          end else n_pass++;
        end
        got++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_total++;
    if (got != 1000 || sent != 1000 || expq.size() != 0)
      $display("FAIL b2b_count: sent=%0d got=%0d pending=%0d required 1000/1000/0",
               sent, got, expq.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sum_sub();
    test_mul_div();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
